// File: rtl/imm_gen_stage_pkg.sv
// Shared types for the immediate-generation stage.
//   ImmGenType : immediate format select driven by the decoder
//   u32        : raw 32-bit instruction word
//   IMM_TYPE_W : bit width of the format select port
package imm_gen_stage_pkg;

    localparam int U32_W = 32;

    typedef logic [U32_W-1:0] u32;

    // Kept 4 bits wide so the decoder can present codes above Gen_ZIMM.
    // Such codes are flagged as bad rather than aliased onto a real format.
    typedef enum logic [3:0] {
        NoGen     = 4'd0,
        Gen_I     = 4'd1,
        Gen_S     = 4'd2,
        Gen_B     = 4'd3,
        Gen_U     = 4'd4,
        Gen_J     = 4'd5,
        Gen_SHAMT = 4'd6,
        Gen_ZIMM  = 4'd7
    } ImmGenType;

    localparam int IMM_TYPE_W = $bits(ImmGenType);

endpackage

// File: rtl/imm_gen_stage_expand.sv
// imm_expand: purely combinational RV64I/Zicsr immediate expansion.
//   instr    in  32          raw instruction
//   imm_type in  IMM_TYPE_W  format select (ImmGenType encoding)
//   imm      out XLEN        expanded immediate (0 for NoGen and for undefined codes)
//   bad      out 1           imm_type is not a defined encoding
module imm_expand
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [U32_W-1:0]      instr,
    input  logic [IMM_TYPE_W-1:0] imm_type,
    output logic [XLEN-1:0]       imm,
    output logic                  bad
);

    // Opcode bits never carry immediate data.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    // Every signed format is first assembled as a 32-bit value, then widened.
    function automatic logic [XLEN-1:0] sext32(input u32 v);
        return XLEN'(signed'(v));
    endfunction

    always_comb begin
        imm = '0;
        bad = 1'b0;
        case (imm_type)
            NoGen:     imm = '0;
            Gen_I:     imm = sext32({{20{instr[31]}}, instr[31:20]});
            Gen_S:     imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
            Gen_B:     imm = sext32({{20{instr[31]}}, instr[7], instr[30:25],
                                     instr[11:8], 1'b0});
            Gen_U:     imm = sext32({instr[31:12], 12'b0});
            Gen_J:     imm = sext32({{12{instr[31]}}, instr[19:12], instr[20],
                                     instr[30:21], 1'b0});
            Gen_SHAMT: begin
                // RV32 shift amounts are 5 bits; bit 25 is then part of funct7.
                if (XLEN == 64) imm = XLEN'(instr[25:20]);
                else            imm = XLEN'(instr[24:20]);
            end
            Gen_ZIMM:  imm = XLEN'(instr[19:15]);
            default:   bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: decode-stage immediate unit with a registered, skid-buffered
// valid/ready output. Sits between decode and the ID/EX register.
//   clk, reset_n       clock; asynchronous active-low reset
//   flush              synchronous kill of every held entry and of a same-cycle accept
//   in_valid/in_ready  producer handshake for {in_instr, in_type, in_tag}
//   in_instr, in_type  raw instruction and immediate format select
//   in_tag             opaque sideband returned unchanged with the result
//   out_valid/out_ready consumer handshake for {out_imm, out_tag, out_bad}
//   out_imm            XLEN-bit expanded immediate
//   out_tag            tag of the presented result
//   out_bad            in_type was undefined (out_imm is 0)
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [U32_W-1:0]      in_instr,
    input  logic [IMM_TYPE_W-1:0] in_type,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_imm,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_bad
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             bad;
    } imm_entry_t;

    // ---- p0: combinational expansion of the offered instruction ----
    logic [XLEN-1:0] exp_imm_p0;
    logic            exp_bad_p0;
    imm_entry_t      exp_p0;

    imm_expand #(.XLEN(XLEN)) u_expand (
        .instr    (in_instr),
        .imm_type (in_type),
        .imm      (exp_imm_p0),
        .bad      (exp_bad_p0)
    );

    assign exp_p0 = '{imm: exp_imm_p0, tag: in_tag, bad: exp_bad_p0};

    // ---- p1: main register (drives outputs) and skid register ----
    imm_entry_t main_p1;
    imm_entry_t skid_p1;
    logic       vld_p1;
    logic       skid_vld_p1;
    logic       accept;
    logic       drain;

    // Ready depends only on registered state, so no out_ready->in_ready path.
    assign in_ready = !skid_vld_p1;
    assign accept   = in_valid && in_ready;
    assign drain    = vld_p1 && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            main_p1     <= '0;
            skid_p1     <= '0;
        end else if (flush) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            main_p1     <= '0;
            skid_p1     <= '0;
        end else if (!vld_p1 || drain) begin
            // Older skid entry always goes first; while it is held in_ready is
            // low, so no accept can coincide with this refill.
            if (skid_vld_p1) begin
                main_p1     <= skid_p1;
                vld_p1      <= 1'b1;
                skid_vld_p1 <= 1'b0;
            end else if (accept) begin
                main_p1 <= exp_p0;
                vld_p1  <= 1'b1;
            end else begin
                vld_p1  <= 1'b0;
            end
        end else if (accept) begin
            skid_p1     <= exp_p0;
            skid_vld_p1 <= 1'b1;
        end
    end

    assign out_valid = vld_p1;
    assign out_imm   = main_p1.imm;
    assign out_tag   = main_p1.tag;
    assign out_bad   = main_p1.bad;

endmodule

// File: tb/tb_imm_gen_stage.sv
module tb_imm_gen_stage;
    import imm_gen_stage_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [3:0]  in_type;
    logic [7:0]  in_tag;

    logic        in_ready, out_valid, out_bad;
    logic [63:0] out_imm;
    logic [7:0]  out_tag;
    logic        in_ready32, out_valid32, out_bad32;
    logic [31:0] out_imm32;
    logic [7:0]  out_tag32;

    int checks   = 0;
    int failures = 0;

    imm_gen_stage #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag), .out_bad(out_bad)
    );

    imm_gen_stage #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32), .out_bad(out_bad32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Value-level model of the immediate formats: {bad, imm}.
    function automatic logic [64:0] model(input logic [31:0] i, input logic [3:0] t,
                                          input int xlen);
        longint v;
        logic   bad;
        v   = 0;
        bad = 1'b0;
        case (t)
            NoGen:     v = 0;
            Gen_I:     begin v = longint'(i[31:20]); if (i[31]) v -= 4096; end
            Gen_S:     begin
                v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
                if (i[31]) v -= 4096;
            end
            Gen_B:     begin
                v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
                if (i[31]) v -= 4096;
            end
            Gen_U:     begin
                v = longint'(i[31:12]) * 4096;
                if (i[31]) v -= 64'sh1_0000_0000;
            end
            Gen_J:     begin
                v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
                  + longint'(i[30:21]) * 2;
                if (i[31]) v -= 1048576;
            end
            Gen_SHAMT: v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
            Gen_ZIMM:  v = longint'(i[19:15]);
            default:   bad = 1'b1;
        endcase
        if (xlen == 32) v = longint'(v[31:0]);
        return {bad, 64'(v)};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  typ;
        logic [7:0]  tag;
    } txn_t;
    txn_t q[$];

    // Scoreboard: queue of accepted items, compared every cycle at the falling edge.
    always @(negedge clk) begin
        logic [64:0] e64;
        logic [64:0] e32;
        logic        rdy_m;
        if (!reset_n) begin
            q.delete();
            chk("rst_out_valid",   out_valid,   0);
            chk("rst_out_valid32", out_valid32, 0);
            chk("rst_in_ready",    in_ready,    1);
            chk("rst_in_ready32",  in_ready32,  1);
        end else begin
            rdy_m = (q.size() < 2);
            chk("in_ready",    in_ready,    rdy_m);
            chk("in_ready32",  in_ready32,  rdy_m);
            chk("out_valid",   out_valid,   q.size() > 0);
            chk("out_valid32", out_valid32, q.size() > 0);
            if (q.size() > 0) begin
                e64 = model(q[0].instr, q[0].typ, 64);
                e32 = model(q[0].instr, q[0].typ, 32);
                chk("out_imm",   out_imm,   e64[63:0]);
                chk("out_bad",   out_bad,   e64[64]);
                chk("out_tag",   out_tag,   q[0].tag);
                chk("out_imm32", out_imm32, e32[63:0]);
                chk("out_bad32", out_bad32, e32[64]);
                chk("out_tag32", out_tag32, q[0].tag);
                if (out_ready) void'(q.pop_front());
            end
            if (flush) q.delete();
            else if (in_valid && rdy_m)
                q.push_back('{instr: in_instr, typ: in_type, tag: in_tag});
        end
    end

    localparam int NV = 12;
    logic [31:0] vi  [NV] = '{32'hFFF00093, 32'hFE000EE3, 32'h800000B7, 32'h0000006F,
                              32'h03F01093, 32'h000FD073, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFE000FA3, 32'h0080006F, 32'h00000463, 32'h00112423};
    logic [3:0]  vt  [NV] = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd15, 4'd0,
                              4'd2, 4'd5, 4'd3, 4'd2};
    logic [63:0] ve64[NV] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC,
                              64'hFFFF_FFFF_8000_0000, 64'h0, 64'h3F, 64'h1F, 64'h0, 64'h0,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'h8, 64'h8, 64'h8};
    logic [31:0] ve32[NV] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h8000_0000, 32'h0, 32'h1F,
                              32'h1F, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h8, 32'h8, 32'h8};
    logic        vb  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [3:0] typ, input logic [7:0] tag);
        in_valid = 1'b1;
        in_instr = instr;
        in_type  = typ;
        in_tag   = tag;
    endtask

    initial begin
        logic [64:0] m;
        reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_type = '0; in_tag = '0;

        // The model itself against hand-computed values.
        for (int k = 0; k < NV; k++) begin
            m = model(vi[k], vt[k], 64);
            chk("model_imm64", m[63:0], ve64[k]);
            chk("model_bad",   m[64],   vb[k]);
            m = model(vi[k], vt[k], 32);
            chk("model_imm32", m[63:0], {32'h0, ve32[k]});
        end

        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Every format, streamed back to back with the consumer always ready.
        out_ready = 1'b1;
        for (int k = 0; k < NV; k++) begin
            drive(vi[k], vt[k], 8'(k + 1));
            tick();
            chk("vec_valid", out_valid, 1);
            chk("vec_imm64", out_imm,   ve64[k]);
            chk("vec_imm32", out_imm32, ve32[k]);
            chk("vec_bad",   out_bad,   vb[k]);
            chk("vec_tag",   out_tag,   k + 1);
        end
        in_valid = 1'b0;
        tick();
        chk("vec_drained", out_valid, 0);

        // Backpressure and output hold.
        out_ready = 1'b0;
        drive(32'h00100093, Gen_I, 8'h01);
        tick();
        chk("bp_in_ready_1", in_ready, 1);
        chk("bp_tag_1",      out_tag,  8'h01);
        drive(32'h00200093, Gen_I, 8'h02);
        tick();
        chk("bp_in_ready_0", in_ready, 0);
        drive(32'h00300093, Gen_I, 8'h03);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("hold_valid",    out_valid, 1);
            chk("hold_tag",      out_tag,   8'h01);
            chk("hold_imm",      out_imm,   64'h1);
            chk("hold_in_ready", in_ready,  0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_tag_2",       out_tag,  8'h02);
        chk("bp_in_ready_up", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_tag_3", out_tag, 8'h03);
        chk("bp_imm_3", out_imm, 64'h3);
        tick();
        chk("bp_empty", out_valid, 0);

        // Flush with main and skid full, and with only main full.
        out_ready = 1'b0;
        drive(32'h00700093, Gen_I, 8'h21);
        tick();
        drive(32'h00800093, Gen_I, 8'h22);
        tick();
        drive(32'h00900093, Gen_I, 8'h23);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid,   0);
        chk("flush_in_ready",  in_ready,    1);
        chk("flush_valid32",   out_valid32, 0);
        drive(32'h00A00093, Gen_I, 8'h24);
        tick();
        drive(32'h00B00093, Gen_I, 8'h25);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush2_out_valid", out_valid, 0);
        chk("flush2_in_ready",  in_ready,  1);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("flush_nothing_left", out_valid, 0);

        // Asynchronous reset in the middle of a stream.
        out_ready = 1'b0;
        drive(32'h00C00093, Gen_I, 8'h31);
        tick();
        drive(32'h00D00093, Gen_I, 8'h32);
        tick();
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out_valid",   out_valid,   0);
        chk("arst_out_valid32", out_valid32, 0);
        chk("arst_in_ready",    in_ready,    1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        drive(32'h00500093, Gen_I, 8'h41);
        tick();
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_tag",   out_tag,   8'h41);
        chk("post_rst_imm",   out_imm,   64'h5);
        tick();
        chk("post_rst_empty", out_valid, 0);

        // Mixed traffic with intermittent valid and ready; scoreboard does the checking.
        for (int c = 0; c < 48; c++) begin
            in_valid  = (c % 3) != 2;
            out_ready = (c % 5) < 3;
            in_instr  = {12'(c * 37), 20'h00093};
            in_type   = 4'(c % 9);
            in_tag    = 8'(c + 8'h50);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("final_empty", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
